muldiv_hilo_ctrl: RTL and testbench

Sequencer and HI/LO register owner sitting directly downstream of the iterative divider and multiplier in the datapath. Accepts a mult/div launch from the control unit, holds operands stable, clears and runs the selected unit, and waits its fixed iteration count. It then captures the unit's HI/LO results into architectural HI/LO registers and signals completion and divide-by-zero. Also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_hilo_ctrl_hilo_reg.sv | 41 ++++
 rtl/muldiv_hilo_ctrl.sv | 140 ++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the mult/div sequencer and its HI/LO register file:
//   sequencer state encoding, op_sel codes and the default iteration counts of
//   the iterative divider and multiplier.
//   No ports (package).

package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_CAPTURE,
        ST_ZERO
    } state_t;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_MULT = 1'b1;

    // RUN-state cycles each unit needs after its clear cycle
    localparam int DEF_DIV_CYCLES  = 33;
    localparam int DEF_MULT_CYCLES = 33;

endpackage

// File: rtl/muldiv_hilo_ctrl_hilo_reg.sv
// hilo_reg
//   Architectural HI/LO register pair. Cleared by reset, loaded together from
//   a finished mult/div unit on capture, or written individually by mthi/mtlo.
//   Capture wins over the individual writes; the parent gates the writes so
//   they only land while the sequencer is idle.
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-low reset
//   cap_en         load both registers from cap_hi/cap_lo
//   cap_hi/cap_lo  unit result halves
//   hi_we/lo_we    mthi/mtlo write enables
//   wdata          mthi/mtlo write data
//   hi/lo          register contents

module hilo_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_en,
    input  logic [31:0] cap_hi,
    input  logic [31:0] cap_lo,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (cap_en) begin
            hi <= cap_hi;
            lo <= cap_lo;
        end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
//   Sequencer for the iterative divider/multiplier plus owner of HI/LO.
//   Accepts a launch in IDLE, registers the operands for the units, clears the
//   selected unit for one cycle, waits its fixed iteration count, then captures
//   the unit result into HI/LO with a one-cycle done pulse. A divide by zero
//   skips the units entirely and finishes one cycle after launch.
// Ports:
//   clk, reset                 clock / synchronous active-low reset
//   op_start, op_sel           launch request, 0 = divide, 1 = multiply
//   op_a, op_b                 operands
//   wdata, mthi_we, mtlo_we    mthi/mtlo write port (IDLE only)
//   div_hi/div_lo/div_exc      divider results and exception flag
//   mult_hi/mult_lo            multiplier product halves
//   unit_clr                   clear to both units
//   unit_a, unit_b             registered operands to the units
//   hi, lo                     architectural HI/LO
//   busy, done, div_zero       status to the control unit

module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] wdata,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_exc,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        unit_clr,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    state_t             state;
    logic               op_sel_q;
    logic [CNT_W-1:0]   cnt;
    logic               is_idle;
    logic               cap_en;
    logic [31:0]        cap_hi;
    logic [31:0]        cap_lo;

    // The units are held in clear during reset as well as in LAUNCH, so an
    // aborted operation never leaves stale iteration state behind.
    assign unit_clr = ~reset | (state == ST_LAUNCH);

    assign is_idle = (state == ST_IDLE);
    assign cap_en  = (state == ST_CAPTURE);
    assign cap_hi  = (op_sel_q == OP_MULT) ? mult_hi : div_hi;
    assign cap_lo  = (op_sel_q == OP_MULT) ? mult_lo : div_lo;

    hilo_reg u_hilo (
        .clk    (clk),
        .reset  (reset),
        .cap_en (cap_en),
        .cap_hi (cap_hi),
        .cap_lo (cap_lo),
        .hi_we  (mthi_we & is_idle),
        .lo_we  (mtlo_we & is_idle),
        .wdata  (wdata),
        .hi     (hi),
        .lo     (lo)
    );

    // Sequencer. done/div_zero default low every cycle so they can only ever
    // be single-cycle pulses out of CAPTURE or ZERO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            op_sel_q <= OP_DIV;
            unit_a   <= '0;
            unit_b   <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_start) begin
                        unit_a   <= op_a;
                        unit_b   <= op_b;
                        op_sel_q <= op_sel;
                        busy     <= 1'b1;
                        // Zero divisor is resolved here without touching the divider
                        if (op_sel == OP_DIV && op_b == '0)
                            state <= ST_ZERO;
                        else
                            state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= (op_sel_q == OP_MULT) ? CNT_W'(MULT_CYCLES - 1)
                                                   : CNT_W'(DIV_CYCLES - 1);
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (cnt == '0)
                        state <= ST_CAPTURE;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_CAPTURE: begin
                    done     <= 1'b1;
                    div_zero <= (op_sel_q == OP_DIV) & div_exc;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                ST_ZERO: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl
//   Directed bench for muldiv_hilo_ctrl. Behavioural divider/multiplier models
//   drive the unit inputs; their results only become valid once the unit has
//   run its full iteration count after a clear, so early capture shows up as
//   a garbage value in HI/LO.

module tb_muldiv_hilo_ctrl;

    logic        clk;
    logic        reset;
    logic        op_start;
    logic        op_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] wdata;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_exc;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        unit_clr;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int e0_cyc = 0;
    int unit_cnt = 0;
    int clr_cycles = 0;
    int done_pulses = 0;

    localparam int UNIT_CYCLES = 33;
    localparam logic [31:0] GARBAGE = 32'hBADBAD00;

    muldiv_hilo_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .op_start (op_start),
        .op_sel   (op_sel),
        .op_a     (op_a),
        .op_b     (op_b),
        .wdata    (wdata),
        .mthi_we  (mthi_we),
        .mtlo_we  (mtlo_we),
        .div_hi   (div_hi),
        .div_lo   (div_lo),
        .div_exc  (div_exc),
        .mult_hi  (mult_hi),
        .mult_lo  (mult_lo),
        .unit_clr (unit_clr),
        .unit_a   (unit_a),
        .unit_b   (unit_b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (unit_clr) unit_cnt <= 0;
        else          unit_cnt <= unit_cnt + 1;
    end

    always @(negedge clk) begin
        if (unit_clr === 1'b1) clr_cycles++;
        if (done === 1'b1)     done_pulses++;
    end

    // Unit models: results valid only after a full run following a clear
    logic [63:0] prod;
    always_comb begin
        prod    = 64'(unit_a) * 64'(unit_b);
        div_exc = (unit_b == 32'd0);
        if (unit_cnt >= UNIT_CYCLES) begin
            div_hi  = (unit_b == 32'd0) ? 32'd0 : unit_a % unit_b;
            div_lo  = (unit_b == 32'd0) ? 32'd0 : unit_a / unit_b;
            mult_hi = prod[63:32];
            mult_lo = prod[31:0];
        end else begin
            div_hi  = GARBAGE;
            div_lo  = GARBAGE;
            mult_hi = GARBAGE;
            mult_lo = GARBAGE;
        end
    end

    typedef struct {
        string       name;
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch an op; returns at the negedge after the accepting edge E0
    task automatic startOp(input logic sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_start = 1'b1;
        op_sel   = sel;
        op_a     = a;
        op_b     = b;
        clr_cycles  = 0;
        done_pulses = 0;
        @(negedge clk);
        op_start = 1'b0;
        e0_cyc   = cyc;
    endtask

    // Wait (bounded) for done; returns latency in edges after E0
    task automatic waitDone(output int lat);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checkOutput("done_timeout", 32'(done), 32'd1);
            lat = -1;
        end else begin
            lat = cyc - e0_cyc;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat;
        startOp(v.sel, v.a, v.b);
        checkOutput({v.name, "_clr_launch"}, 32'(unit_clr), 32'd1);
        checkOutput({v.name, "_busy"}, 32'(busy), 32'd1);
        waitDone(lat);
        checkOutput({v.name, "_latency"}, lat, 32'd35);
        checkOutput({v.name, "_hi"}, hi, v.exp_hi);
        checkOutput({v.name, "_lo"}, lo, v.exp_lo);
        checkOutput({v.name, "_dz"}, 32'(div_zero), 32'(v.exp_dz));
        checkOutput({v.name, "_busy_end"}, 32'(busy), 32'd0);
        checkOutput({v.name, "_clr_cycles"}, clr_cycles, 32'd1);
        @(negedge clk);
        checkOutput({v.name, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses_before;

        vecs[0] = '{"div_100_7",   1'b0, 32'd100,        32'd7,          32'd2,  32'd14,         1'b0};
        vecs[1] = '{"mul_max_2",   1'b1, 32'hFFFFFFFF,   32'd2,          32'd1,  32'hFFFFFFFE,   1'b0};
        vecs[2] = '{"mul_3_4",     1'b1, 32'd3,          32'd4,          32'd0,  32'd12,         1'b0};
        vecs[3] = '{"div_max_16",  1'b0, 32'hFFFFFFFF,   32'h10,         32'hF,  32'h0FFFFFFF,   1'b0};
        vecs[4] = '{"div_7_100",   1'b0, 32'd7,          32'd100,        32'd7,  32'd0,          1'b0};
        vecs[5] = '{"mul_x_0",     1'b1, 32'h1234,       32'd0,          32'd0,  32'd0,          1'b0};

        reset    = 1'b0;
        op_start = 1'b1;
        op_sel   = 1'b0;
        op_a     = 32'd0;
        op_b     = 32'd0;
        wdata    = 32'd0;
        mthi_we  = 1'b0;
        mtlo_we  = 1'b0;

        // Reset held for three edges with a pending start
        repeat (3) @(negedge clk);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_clr", 32'(unit_clr), 32'd1);
        checkOutput("rst_unit_a", unit_a, 32'd0);
        reset    = 1'b1;
        op_start = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_clr", 32'(unit_clr), 32'd0);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // mthi in IDLE, then divide by zero takes the short path
        @(negedge clk);
        mthi_we = 1'b1;
        wdata   = 32'h1234;
        @(negedge clk);
        mthi_we = 1'b0;
        checkOutput("mthi_write", hi, 32'h1234);
        startOp(1'b0, 32'd5, 32'd0);
        checkOutput("zero_clr_e0", 32'(unit_clr), 32'd0);
        waitDone(lat);
        checkOutput("zero_latency", lat, 32'd1);
        checkOutput("zero_dz", 32'(div_zero), 32'd1);
        checkOutput("zero_hi", hi, 32'h1234);
        checkOutput("zero_lo", lo, 32'd0);
        checkOutput("zero_busy", 32'(busy), 32'd0);
        checkOutput("zero_clr_cycles", clr_cycles, 32'd0);
        @(negedge clk);
        checkOutput("zero_dz_width", 32'(div_zero), 32'd0);

        // Start and mtlo during RUN are both ignored
        startOp(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        op_start = 1'b1;
        op_b     = 32'd3;
        mtlo_we  = 1'b1;
        wdata    = 32'hDEAD;
        @(negedge clk);
        op_start = 1'b0;
        mtlo_we  = 1'b0;
        checkOutput("busy_ign_unit_b", unit_b, 32'd7);
        checkOutput("busy_ign_lo", lo, 32'd0);
        waitDone(lat);
        checkOutput("busy_ign_latency", lat, 32'd35);
        checkOutput("busy_ign_lo_final", lo, 32'd14);
        checkOutput("busy_ign_hi_final", hi, 32'd2);
        repeat (40) @(negedge clk);
        checkOutput("busy_ign_done_pulses", done_pulses, 32'd1);

        // Reset ten cycles into a divide aborts it
        startOp(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        pulses_before = done_pulses;
        repeat (40) @(negedge clk);
        checkOutput("abort_no_done", done_pulses - pulses_before, 32'd0);
        checkOutput("abort_busy_idle", 32'(busy), 32'd0);

        startOp(1'b0, 32'd9, 32'd2);
        waitDone(lat);
        checkOutput("after_abort_latency", lat, 32'd35);
        checkOutput("after_abort_hi", hi, 32'd1);
        checkOutput("after_abort_lo", lo, 32'd4);
        checkOutput("after_abort_dz", 32'(div_zero), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
